// File: rtl/inst_seq_ctrl_pkg.sv
// rtl/inst_seq_ctrl_pkg.sv - shared opcodes, field positions and state encoding for the sequencer
package inst_seq_ctrl_pkg;

    // Instruction field bit positions: op=[15:12], D=[11:8], addr=[7:0]
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int D_MSB    = 11;
    localparam int D_LSB    = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JR   = 4'b1001;
    localparam logic [3:0] OP_BEQZ = 4'b1100;
    localparam logic [3:0] OP_BNEZ = 4'b1101;
    localparam logic [3:0] OP_BLTZ = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_BR_EVAL,
        ST_HALT
    } state_t;

    function automatic logic is_ctrl_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JR) || (op == OP_BEQZ) ||
               (op == OP_BNEZ) || (op == OP_BLTZ);
    endfunction

endpackage

// File: rtl/inst_seq_ctrl_if.sv
// rtl/inst_seq_ctrl_if.sv - issue handshake and branch-flag bundle between sequencer and datapath
// master (sequencer): drives ex_valid, ex_op, ex_d, ex_addr; receives ex_ready, flag_z, flag_n, jr_target
// slave  (datapath) : the mirror image
interface inst_seq_ctrl_if #(
    parameter int PC_W = 8
);
    logic            ex_valid;
    logic            ex_ready;
    logic [3:0]      ex_op;
    logic [3:0]      ex_d;
    logic [7:0]      ex_addr;
    logic            flag_z;
    logic            flag_n;
    logic [PC_W-1:0] jr_target;

    modport master (
        output ex_valid, ex_op, ex_d, ex_addr,
        input  ex_ready, flag_z, flag_n, jr_target
    );

    modport slave (
        input  ex_valid, ex_op, ex_d, ex_addr,
        output ex_ready, flag_z, flag_n, jr_target
    );
endinterface

// File: rtl/inst_seq_ctrl_br_resolve.sv
// rtl/inst_seq_ctrl_br_resolve.sv - combinational control-flow resolution
// in : op, flag_z, flag_n, addr, jr_target, pc
// out: is_ctrl (op is a control op), taken, target, self_loop (taken jump to its own pc = halt)
module inst_seq_ctrl_br_resolve
    import inst_seq_ctrl_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [3:0]      op,
    input  logic            flag_z,
    input  logic            flag_n,
    input  logic [7:0]      addr,
    input  logic [PC_W-1:0] jr_target,
    input  logic [PC_W-1:0] pc,
    output logic            is_ctrl,
    output logic            taken,
    output logic [PC_W-1:0] target,
    output logic            self_loop
);

    always_comb begin
        taken  = 1'b0;
        target = PC_W'(addr);
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JR: begin
                taken  = 1'b1;
                target = jr_target;
            end
            OP_BEQZ: taken = flag_z;
            OP_BNEZ: taken = !flag_z;
            OP_BLTZ: taken = flag_n;
            default: taken = 1'b0;
        endcase
    end

    assign is_ctrl   = is_ctrl_op(op);
    assign self_loop = taken && (target == pc);

endmodule

// File: rtl/inst_seq_ctrl.sv
// rtl/inst_seq_ctrl.sv - fetch/issue sequencer: owns pc, fetches, issues, resolves branches, detects halt
// clk, rst (sync active-high), run (start pulse, honoured in IDLE/HALT)
// pc, cache_en, instruction: instruction-cache side (instruction is combinational read of pc)
// ex: issue handshake + branch flags (master side)
// busy (FETCH/ISSUE/BR_EVAL), halted (HALT), retired (saturating completed-instruction count)
module inst_seq_ctrl
    import inst_seq_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [PC_W-1:0]   pc,
    output logic              cache_en,
    input  logic [INST_W-1:0] instruction,
    inst_seq_ctrl_if.master   ex,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    state_t            state;
    logic [INST_W-1:0] ir;
    logic              ex_valid_q;

    logic              is_ctrl;
    logic              taken;
    logic [PC_W-1:0]   target;
    logic              self_loop;

    assign ex.ex_valid = ex_valid_q;
    assign ex.ex_op    = ir[OP_MSB:OP_LSB];
    assign ex.ex_d     = ir[D_MSB:D_LSB];
    assign ex.ex_addr  = ir[ADDR_MSB:ADDR_LSB];

    inst_seq_ctrl_br_resolve #(
        .PC_W (PC_W)
    ) u_br_resolve (
        .op        (ir[OP_MSB:OP_LSB]),
        .flag_z    (ex.flag_z),
        .flag_n    (ex.flag_n),
        .addr      (ir[ADDR_MSB:ADDR_LSB]),
        .jr_target (ex.jr_target),
        .pc        (pc),
        .is_ctrl   (is_ctrl),
        .taken     (taken),
        .target    (target),
        .self_loop (self_loop)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            retired    <= '0;
            ex_valid_q <= 1'b0;
            cache_en   <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (run) begin
                        pc       <= RESET_PC;
                        retired  <= '0;
                        cache_en <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir         <= instruction;
                    ex_valid_q <= 1'b1;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (ex.ex_ready) begin
                        ex_valid_q <= 1'b0;
                        if (is_ctrl) begin
                            state <= ST_BR_EVAL;
                        end else begin
                            pc      <= pc + PC_W'(1);
                            retired <= sat_inc(retired);
                            state   <= ST_FETCH;
                        end
                    end
                end
                ST_BR_EVAL: begin
                    retired <= sat_inc(retired);
                    if (self_loop) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        pc    <= taken ? target : pc + PC_W'(1);
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    ex_valid_q <= 1'b0;
                    busy       <= 1'b0;
                    halted     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
